// File: rtl/tick_counter.sv
// Consumer of the divided-clock square wave: synchronises tick_in into clk,
// converts rising edges to step pulses that drive a modulo up/down counter and a stall watchdog.
module tick_counter #(
  parameter int               WIDTH   = 8,
  parameter logic [WIDTH-1:0] MAX     = 8'd9,
  parameter logic [27:0]      TIMEOUT = 28'd20000000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tick_in,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             step,
  output logic             wrap,
  output logic             stalled
);

  logic        tick_p0;
  logic        tick_p1;
  logic        tick_p2;
  logic        vld_p2;
  logic [27:0] gap;

  function automatic logic [WIDTH-1:0] sat_load(input logic [WIDTH-1:0] v);
    return (v > MAX) ? MAX : v;
  endfunction

  // An out-of-range count is treated as MAX, so it always wraps back into range.
  function automatic logic [WIDTH-1:0] inc_mod(input logic [WIDTH-1:0] v);
    return (v >= MAX) ? '0 : v + WIDTH'(1);
  endfunction

  function automatic logic [WIDTH-1:0] dec_mod(input logic [WIDTH-1:0] v);
    return (v == '0) ? MAX : v - WIDTH'(1);
  endfunction

  // Stages p0..p2: synchroniser chain, p0/p1 resolve metastability, p2 holds the previous level.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tick_p0 <= 1'b0;
      tick_p1 <= 1'b0;
      tick_p2 <= 1'b0;
    end else begin
      tick_p0 <= tick_in;
      tick_p1 <= tick_p0;
      tick_p2 <= tick_p1;
    end
  end

  assign vld_p2 = tick_p1 & ~tick_p2;

  // Stage p3: counter, step and wrap registers, load has priority over an accepted edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
      step  <= 1'b0;
      wrap  <= 1'b0;
    end else begin
      step <= vld_p2;
      if (load) begin
        count <= sat_load(load_val);
        wrap  <= 1'b0;
      end else if (vld_p2 && en) begin
        if (up) begin
          count <= inc_mod(count);
          wrap  <= (count >= MAX);
        end else begin
          count <= dec_mod(count);
          wrap  <= (count == '0);
        end
      end else begin
        wrap <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      gap <= '0;
    end else if (vld_p2) begin
      gap <= '0;
    end else if (gap < TIMEOUT) begin
      gap <= gap + 28'd1;
    end
  end

  assign stalled = (gap == TIMEOUT);

endmodule

// File: tb/tb_tick_counter.sv
// Bench for tick_counter: directed scenarios plus randomized tick waveforms, checked every
// cycle against an edge-history reference model.
module tb_tick_counter;

  localparam int MAXV = 9;
  localparam int TO   = 16;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       tick_in = 1'b0;
  logic       en = 1'b0;
  logic       up = 1'b0;
  logic       load = 1'b0;
  logic [7:0] load_val = 8'd0;
  logic [7:0] count;
  logic       step;
  logic       wrap;
  logic       stalled;

  int checks = 0;
  int errors = 0;

  // Reference model state: tick_in levels sampled at each edge since reset release.
  bit hist[$];
  int m_cnt = 0;
  int m_since = 0;
  bit m_rise = 0;
  bit m_wrap = 0;
  int sec_steps = 0;
  int sec_wraps = 0;

  tick_counter #(.WIDTH(8), .MAX(8'd9), .TIMEOUT(28'd16)) dut (
    .clk(clk), .reset(reset), .tick_in(tick_in), .en(en), .up(up), .load(load),
    .load_val(load_val), .count(count), .step(step), .wrap(wrap), .stalled(stalled)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  // One clock edge: advance the model with the inputs sampled at that edge, then compare.
  task automatic clk_step();
    int n;
    @(posedge clk);
    #1;
    n = hist.size();
    hist.push_back(tick_in);
    // An edge is accepted two edges after the first high sample following a low one.
    m_rise = (n >= 2) && hist[n-2] && ((n < 3) || !hist[n-3]);
    m_wrap = 1'b0;
    if (load) begin
      m_cnt = (int'(load_val) > MAXV) ? MAXV : int'(load_val);
    end else if (m_rise && en) begin
      if (up) begin
        m_wrap = (m_cnt == MAXV);
        m_cnt  = (m_cnt + 1) % (MAXV + 1);
      end else begin
        m_wrap = (m_cnt == 0);
        m_cnt  = (m_cnt + MAXV) % (MAXV + 1);
      end
    end
    m_since = m_rise ? 0 : m_since + 1;
    chk("count", count, m_cnt);
    chk("step", step, m_rise);
    chk("wrap", wrap, m_wrap);
    chk("stalled", stalled, (m_since >= TO));
    if (step === 1'b1) sec_steps++;
    if (wrap === 1'b1) sec_wraps++;
  endtask

  // Asserts reset between clock edges, checks outputs clear without a clock, releases on negedge.
  task automatic do_reset(input logic tick_lvl);
    #2;
    reset   = 1'b1;
    tick_in = tick_lvl;
    #1;
    chk("rst_count", count, 0);
    chk("rst_step", step, 0);
    chk("rst_wrap", wrap, 0);
    chk("rst_stalled", stalled, 0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    hist.delete();
    m_cnt   = 0;
    m_since = 0;
  endtask

  task automatic tick_period(input int hi, input int lo);
    tick_in = 1'b1;
    repeat (hi) clk_step();
    tick_in = 1'b0;
    repeat (lo) clk_step();
  endtask

  initial begin
    int hi;
    int lo;
    do_reset(1'b0);

    // Up count with wrap at 9 -> 0.
    en = 1'b1; up = 1'b1;
    sec_steps = 0; sec_wraps = 0;
    repeat (12) tick_period(4, 4);
    chk("up_final", count, 2);
    chk("up_steps", sec_steps, 12);
    chk("up_wraps", sec_wraps, 1);

    // Down count through 0 -> 9.
    load = 1'b1; load_val = 8'd2;
    clk_step();
    load = 1'b0; up = 1'b0;
    sec_steps = 0; sec_wraps = 0;
    repeat (4) tick_period(4, 4);
    chk("down_final", count, 8);
    chk("down_wraps", sec_wraps, 1);

    // Enable low: steps still pulse, count frozen.
    en = 1'b0;
    sec_steps = 0;
    repeat (3) tick_period(4, 4);
    chk("en_hold", count, 8);
    chk("en_steps", sec_steps, 3);

    // Load coinciding with an accepted edge: clamped load wins.
    en = 1'b1; up = 1'b1;
    tick_in = 1'b1;
    clk_step();
    clk_step();
    load = 1'b1; load_val = 8'd200;
    clk_step();
    chk("load_clamp", count, 9);
    chk("load_step", step, 1);
    chk("load_wrap", wrap, 0);
    load = 1'b0;
    clk_step();
    tick_in = 1'b0;
    repeat (4) clk_step();

    // Async reset with count at 5.
    load = 1'b1; load_val = 8'd5;
    clk_step();
    load = 1'b0;
    chk("pre_reset", count, 5);
    do_reset(1'b0);

    // Watchdog from reset release, then recovery and re-stall.
    repeat (15) clk_step();
    chk("wd_edge15", stalled, 0);
    clk_step();
    chk("wd_edge16", stalled, 1);
    repeat (5) clk_step();
    chk("wd_hold", stalled, 1);
    tick_in = 1'b1;
    clk_step();
    clk_step();
    chk("wd_e1", stalled, 1);
    clk_step();
    chk("wd_e2", stalled, 0);
    clk_step();
    tick_in = 1'b0;
    repeat (14) clk_step();
    chk("wd_re15", stalled, 0);
    clk_step();
    chk("wd_re16", stalled, 1);

    // tick_in held high through reset release yields exactly one step.
    en = 1'b1; up = 1'b1;
    do_reset(1'b1);
    sec_steps = 0;
    repeat (10) clk_step();
    chk("hi_rel_steps", sec_steps, 1);
    chk("hi_rel_count", count, 1);
    tick_in = 1'b0;
    repeat (4) clk_step();
    tick_in = 1'b1;
    repeat (4) clk_step();
    chk("hi_rel_steps2", sec_steps, 2);
    chk("hi_rel_count2", count, 2);

    // Randomized waveforms, controls, loads, long gaps and occasional resets.
    for (int it = 0; it < 60; it++) begin
      en = ($urandom_range(0, 3) != 0);
      up = $urandom_range(0, 1);
      hi = $urandom_range(2, 5);
      lo = ($urandom_range(0, 7) == 0) ? $urandom_range(14, 22) : $urandom_range(2, 5);
      tick_in = 1'b1;
      for (int c = 0; c < hi + lo; c++) begin
        if (c == hi) tick_in = 1'b0;
        load     = ($urandom_range(0, 11) == 0);
        load_val = 8'($urandom_range(0, 255));
        clk_step();
      end
      load = 1'b0;
      if ($urandom_range(0, 14) == 0) do_reset(1'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
